// File: rtl/async_fifo_lvl.sv
// Dual-clock FIFO with Gray-coded pointer crossing, show-ahead or registered read,
// almost-full/almost-empty thresholds, per-domain fill counts and overflow/underflow pulses.
module async_fifo_lvl #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned FWFT        = 1,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned AF_LEVEL    = 252,
  parameter int unsigned AE_LEVEL    = 4
) (
  input  logic              wr_clk,
  input  logic              rd_clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   wr_count,
  output logic              overflow,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              valid,
  output logic              empty,
  output logic              almost_empty,
  output logic [ADDR_W:0]   rd_count,
  output logic              underflow
);

  localparam int unsigned PTR_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [PTR_W-1:0] AF_LVL = PTR_W'(AF_LEVEL);
  localparam logic [PTR_W-1:0] AE_LVL = PTR_W'(AE_LEVEL);

  if (ADDR_W < 2) begin : g_bad_addr_w
    $fatal(1, "async_fifo_lvl: ADDR_W must be >= 2");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $fatal(1, "async_fifo_lvl: SYNC_STAGES must be in 2..4");
  end
  if (AE_LEVEL == 0 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH) begin : g_bad_levels
    $fatal(1, "async_fifo_lvl: need 0 < AE_LEVEL < AF_LEVEL <= 2**ADDR_W");
  end

  function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
    logic [PTR_W-1:0] b;
    b[PTR_W-1] = g[PTR_W-1];
    for (int i = int'(PTR_W) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [DATA_W-1:0] r_mem [DEPTH];

  // ---------------- write domain ----------------
  logic [PTR_W-1:0] r_wr_bin;
  logic [PTR_W-1:0] r_wr_gray;
  logic [PTR_W-1:0] r_rd_gray_sync [SYNC_STAGES];
  logic [PTR_W-1:0] w_wr_bin_nxt;
  logic [PTR_W-1:0] w_rd_gray_wr;
  logic             w_wr_accept;
  logic             r_overflow;

  logic [PTR_W-1:0] r_rd_gray;

  assign w_rd_gray_wr = r_rd_gray_sync[SYNC_STAGES-1];
  assign w_wr_accept  = wr_en & ~full;
  assign w_wr_bin_nxt = r_wr_bin + PTR_W'(w_wr_accept);

  // Full when the write side is exactly one lap ahead: top two Gray bits differ.
  assign full        = (r_wr_gray == {~w_rd_gray_wr[PTR_W-1:PTR_W-2], w_rd_gray_wr[PTR_W-3:0]});
  assign wr_count    = r_wr_bin - gray2bin(w_rd_gray_wr);
  assign almost_full = (wr_count >= AF_LVL);
  assign overflow    = r_overflow;

  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      r_wr_bin   <= '0;
      r_wr_gray  <= '0;
      r_overflow <= 1'b0;
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        r_rd_gray_sync[i] <= '0;
      end
    end else begin
      r_wr_bin          <= w_wr_bin_nxt;
      r_wr_gray         <= w_wr_bin_nxt ^ (w_wr_bin_nxt >> 1);
      r_overflow        <= wr_en & full;
      r_rd_gray_sync[0] <= r_rd_gray;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        r_rd_gray_sync[i] <= r_rd_gray_sync[i-1];
      end
    end
  end

  always_ff @(posedge wr_clk) begin
    if (w_wr_accept) begin
      r_mem[r_wr_bin[ADDR_W-1:0]] <= din;
    end
  end

  // ---------------- read domain ----------------
  logic [PTR_W-1:0] r_rd_bin;
  logic [PTR_W-1:0] r_wr_gray_sync [SYNC_STAGES];
  logic [PTR_W-1:0] w_rd_bin_nxt;
  logic [PTR_W-1:0] w_wr_gray_rd;
  logic             w_rd_accept;
  logic             r_underflow;

  assign w_wr_gray_rd = r_wr_gray_sync[SYNC_STAGES-1];
  assign w_rd_accept  = rd_en & ~empty;
  assign w_rd_bin_nxt = r_rd_bin + PTR_W'(w_rd_accept);

  assign empty        = (r_rd_gray == w_wr_gray_rd);
  assign rd_count     = gray2bin(w_wr_gray_rd) - r_rd_bin;
  assign almost_empty = (rd_count <= AE_LVL);
  assign underflow    = r_underflow;

  always_ff @(posedge rd_clk or posedge rst) begin
    if (rst) begin
      r_rd_bin    <= '0;
      r_rd_gray   <= '0;
      r_underflow <= 1'b0;
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        r_wr_gray_sync[i] <= '0;
      end
    end else begin
      r_rd_bin          <= w_rd_bin_nxt;
      r_rd_gray         <= w_rd_bin_nxt ^ (w_rd_bin_nxt >> 1);
      r_underflow       <= rd_en & empty;
      r_wr_gray_sync[0] <= r_wr_gray;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        r_wr_gray_sync[i] <= r_wr_gray_sync[i-1];
      end
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Show-ahead: the head entry is always on dout; rd_en acknowledges it.
    assign dout  = r_mem[r_rd_bin[ADDR_W-1:0]];
    assign valid = ~empty;
  end else begin : g_regd
    logic [DATA_W-1:0] r_dout;
    logic              r_valid;

    always_ff @(posedge rd_clk or posedge rst) begin
      if (rst) begin
        r_dout  <= '0;
        r_valid <= 1'b0;
      end else begin
        r_valid <= w_rd_accept;
        if (w_rd_accept) begin
          r_dout <= r_mem[r_rd_bin[ADDR_W-1:0]];
        end
      end
    end

    assign dout  = r_dout;
    assign valid = r_valid;
  end

endmodule

// File: tb/tb_async_fifo_lvl.sv
// Scoreboard bench for async_fifo_lvl: a show-ahead instance and a registered-read instance
// share clocks and reset; monitors pop expected words whenever a read is presented.
`timescale 1ns/1ps
module tb_async_fifo_lvl;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;
  localparam int unsigned SS = 2;
  localparam int unsigned AF = 12;
  localparam int unsigned AE = 4;

  logic          wr_clk = 1'b0;
  logic          rd_clk = 1'b0;
  logic          rst    = 1'b1;
  realtime       rd_half = 13.5;

  logic          wr_en_a = 1'b0, rd_en_a = 1'b0;
  logic [DW-1:0] din_a = '0, dout_a;
  logic          full_a, almost_full_a, overflow_a, valid_a, empty_a, almost_empty_a, underflow_a;
  logic [AW:0]   wr_count_a, rd_count_a;

  logic          wr_en_b = 1'b0, rd_en_b = 1'b0;
  logic [DW-1:0] din_b = '0, dout_b;
  logic          full_b, almost_full_b, overflow_b, valid_b, empty_b, almost_empty_b, underflow_b;
  logic [AW:0]   wr_count_b, rd_count_b;

  int            n_checks = 0;
  int            n_pass   = 0;
  int            n_pop_a  = 0;
  int            n_ovf    = 0;
  int            n_unf    = 0;
  bit            watch    = 1'b0;
  logic [DW-1:0] qa [$];
  logic [DW-1:0] qb [$];

  async_fifo_lvl #(
    .DATA_W(DW), .ADDR_W(AW), .FWFT(1), .SYNC_STAGES(SS), .AF_LEVEL(AF), .AE_LEVEL(AE)
  ) u_dut_a (
    .wr_clk(wr_clk), .rd_clk(rd_clk), .rst(rst),
    .wr_en(wr_en_a), .din(din_a), .full(full_a), .almost_full(almost_full_a),
    .wr_count(wr_count_a), .overflow(overflow_a),
    .rd_en(rd_en_a), .dout(dout_a), .valid(valid_a), .empty(empty_a),
    .almost_empty(almost_empty_a), .rd_count(rd_count_a), .underflow(underflow_a)
  );

  async_fifo_lvl #(
    .DATA_W(DW), .ADDR_W(AW), .FWFT(0), .SYNC_STAGES(SS), .AF_LEVEL(AF), .AE_LEVEL(AE)
  ) u_dut_b (
    .wr_clk(wr_clk), .rd_clk(rd_clk), .rst(rst),
    .wr_en(wr_en_b), .din(din_b), .full(full_b), .almost_full(almost_full_b),
    .wr_count(wr_count_b), .overflow(overflow_b),
    .rd_en(rd_en_b), .dout(dout_b), .valid(valid_b), .empty(empty_b),
    .almost_empty(almost_empty_b), .rd_count(rd_count_b), .underflow(underflow_b)
  );

  initial forever #5 wr_clk = ~wr_clk;
  initial forever #(rd_half) rd_clk = ~rd_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Show-ahead monitor: a word is consumed when valid and rd_en meet at a rd_clk edge.
  always @(negedge rd_clk) begin
    if (!rst && valid_a && rd_en_a) begin
      if (qa.size() == 0) begin
        n_checks++;
        $display("FAIL a_extra_word: got dout 0x%0h, expected no word", dout_a);
      end else begin
        check("a_dout", 32'(dout_a), 32'(qa.pop_front()));
      end
      n_pop_a++;
    end
  end

  always @(negedge rd_clk) begin
    if (!rst && valid_b) begin
      if (qb.size() == 0) begin
        n_checks++;
        $display("FAIL b_extra_word: got dout 0x%0h, expected no word", dout_b);
      end else begin
        check("b_dout", 32'(dout_b), 32'(qb.pop_front()));
      end
    end
  end

  always @(negedge wr_clk) if (watch && overflow_a) n_ovf++;
  always @(negedge rd_clk) if (watch && underflow_a) n_unf++;

  task automatic wr_a(input logic [DW-1:0] d);
    @(posedge wr_clk); #1; wr_en_a = 1'b1; din_a = d;
    @(posedge wr_clk); #1; wr_en_a = 1'b0;
  endtask

  task automatic rd_a();
    @(posedge rd_clk); #1; rd_en_a = 1'b1;
    @(posedge rd_clk); #1; rd_en_a = 1'b0;
  endtask

  task automatic settle_rd();
    repeat (SS + 2) @(posedge rd_clk);
    #1;
  endtask

  task automatic settle_wr();
    repeat (SS + 2) @(posedge wr_clk);
    #1;
  endtask

  task automatic rand_writer(input int n);
    int sent = 0;
    int guard = 0;
    while (sent < n && guard < 20000) begin
      @(posedge wr_clk); #1;
      guard++;
      if (!full_a && $urandom_range(0, 3) != 0) begin
        wr_en_a = 1'b1;
        din_a   = DW'($urandom);
        qa.push_back(din_a);
        sent++;
      end else begin
        wr_en_a = 1'b0;
      end
    end
    @(posedge wr_clk); #1; wr_en_a = 1'b0;
    if (sent < n) check("c4_writer_timeout", 32'(sent), 32'(n));
  endtask

  task automatic rand_reader(input int target);
    int guard = 0;
    while (n_pop_a < target && guard < 40000) begin
      @(posedge rd_clk); #1;
      guard++;
      rd_en_a = !empty_a && ($urandom_range(0, 3) != 0);
    end
    rd_en_a = 1'b0;
    if (n_pop_a < target) check("c4_reader_timeout", 32'(n_pop_a), 32'(target));
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int tgt;

    // Reset values while held and after release.
    repeat (3) @(posedge wr_clk);
    #1;
    check("rst_empty", 32'(empty_a), 32'd1);
    check("rst_full", 32'(full_a), 32'd0);
    @(posedge wr_clk); #1; rst = 1'b0;
    settle_rd();
    check("rst_almost_empty", 32'(almost_empty_a), 32'd1);
    check("rst_almost_full", 32'(almost_full_a), 32'd0);
    check("rst_wr_count", 32'(wr_count_a), 32'd0);
    check("rst_rd_count", 32'(rd_count_a), 32'd0);
    check("rst_valid", 32'(valid_a), 32'd0);
    check("rst_valid_b", 32'(valid_b), 32'd0);
    check("rst_overflow", 32'(overflow_a), 32'd0);
    check("rst_underflow", 32'(underflow_a), 32'd0);

    // Case 1: fill to full, then one overflowing write.
    for (int k = 1; k <= 16; k++) begin
      wr_a(DW'(k));
      qa.push_back(DW'(k));
      check("c1_wr_count", 32'(wr_count_a), 32'(k));
      check("c1_almost_full", 32'(almost_full_a), 32'(k >= int'(AF)));
      check("c1_full", 32'(full_a), 32'(k == 16));
    end
    wr_a(8'h11);
    check("c1_overflow_pulse", 32'(overflow_a), 32'd1);
    check("c1_wr_count_hold", 32'(wr_count_a), 32'd16);
    @(posedge wr_clk); #1;
    check("c1_overflow_clear", 32'(overflow_a), 32'd0);
    settle_rd();
    check("c1_rd_count", 32'(rd_count_a), 32'd16);
    check("c1_valid", 32'(valid_a), 32'd1);

    // Case 2: continuous drain plus one extra read.
    @(posedge rd_clk); #1; rd_en_a = 1'b1;
    repeat (16) @(posedge rd_clk);
    #1;
    check("c2_valid_low", 32'(valid_a), 32'd0);
    check("c2_empty", 32'(empty_a), 32'd1);
    @(posedge rd_clk); #1;
    check("c2_underflow_pulse", 32'(underflow_a), 32'd1);
    check("c2_rd_count", 32'(rd_count_a), 32'd0);
    check("c2_almost_empty", 32'(almost_empty_a), 32'd1);
    rd_en_a = 1'b0;
    @(posedge rd_clk); #1;
    check("c2_underflow_clear", 32'(underflow_a), 32'd0);
    check("c2_all_popped", 32'(qa.size()), 32'd0);
    check("c2_pop_count", 32'(n_pop_a), 32'd16);

    // Case 3: registered read latency and hold.
    @(posedge wr_clk); #1; wr_en_b = 1'b1; din_b = 8'hA5; qb.push_back(8'hA5);
    @(posedge wr_clk);
    fork
      begin #1; wr_en_b = 1'b0; end
    join_none
    e = 0;
    while (e < 10) begin
      @(posedge rd_clk); #1;
      e++;
      if (!empty_b) break;
    end
    check("c3_empty_lag_in_range", 32'(e >= int'(SS) && e <= int'(SS) + 1), 32'd1);
    check("c3_valid_before_read", 32'(valid_b), 32'd0);
    @(posedge rd_clk); #1; rd_en_b = 1'b1;
    @(posedge rd_clk); #1; rd_en_b = 1'b0;
    check("c3_valid", 32'(valid_b), 32'd1);
    check("c3_dout", 32'(dout_b), 32'hA5);
    @(posedge rd_clk); #1;
    check("c3_valid_drop", 32'(valid_b), 32'd0);
    check("c3_dout_hold", 32'(dout_b), 32'hA5);
    check("c3_empty_after", 32'(empty_b), 32'd1);

    // Case 6: threshold boundaries.
    for (int k = 0; k < 15; k++) begin
      wr_a(DW'(8'h20 + k));
      qa.push_back(DW'(8'h20 + k));
    end
    check("c6_wr_count15", 32'(wr_count_a), 32'd15);
    check("c6_full15", 32'(full_a), 32'd0);
    check("c6_almost_full15", 32'(almost_full_a), 32'd1);
    settle_rd();
    check("c6_rd_count15", 32'(rd_count_a), 32'd15);
    repeat (11) rd_a();
    check("c6_rd_count4", 32'(rd_count_a), 32'd4);
    check("c6_almost_empty4", 32'(almost_empty_a), 32'd1);
    wr_a(8'h40);
    qa.push_back(8'h40);
    settle_rd();
    check("c6_rd_count5", 32'(rd_count_a), 32'd5);
    check("c6_almost_empty5", 32'(almost_empty_a), 32'd0);
    settle_wr();
    check("c6_wr_count5", 32'(wr_count_a), 32'd5);
    check("c6_almost_full5", 32'(almost_full_a), 32'd0);

    // Case 5: reset with 9 words stored.
    for (int k = 0; k < 4; k++) begin
      wr_a(DW'(8'h50 + k));
      qa.push_back(DW'(8'h50 + k));
    end
    settle_rd();
    check("c5_rd_count9", 32'(rd_count_a), 32'd9);
    @(posedge rd_clk); #1; rst = 1'b1;
    qa.delete();
    repeat (2) @(posedge rd_clk);
    #1; rst = 1'b0;
    settle_rd();
    check("c5_empty", 32'(empty_a), 32'd1);
    check("c5_valid", 32'(valid_a), 32'd0);
    check("c5_rd_count", 32'(rd_count_a), 32'd0);
    check("c5_almost_empty", 32'(almost_empty_a), 32'd1);
    check("c5_wr_count", 32'(wr_count_a), 32'd0);
    check("c5_full", 32'(full_a), 32'd0);
    check("c5_almost_full", 32'(almost_full_a), 32'd0);
    check("c5_overflow", 32'(overflow_a), 32'd0);
    wr_a(8'h3C);
    qa.push_back(8'h3C);
    settle_rd();
    check("c5_rd_count1", 32'(rd_count_a), 32'd1);
    rd_a();
    check("c5_drained", 32'(qa.size()), 32'd0);

    // Case 4: randomized concurrent streaming, fast then slow reader.
    watch = 1'b1;
    rd_half = 3.5;
    tgt = n_pop_a + 500;
    fork
      rand_writer(500);
      rand_reader(tgt);
    join
    rd_half = 13.5;
    tgt = n_pop_a + 500;
    fork
      rand_writer(500);
      rand_reader(tgt);
    join
    watch = 1'b0;
    check("c4_no_overflow", 32'(n_ovf), 32'd0);
    check("c4_no_underflow", 32'(n_unf), 32'd0);
    check("c4_all_delivered", 32'(qa.size()), 32'd0);
    settle_rd();
    check("c4_empty_end", 32'(empty_a), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
